rst_seq_sync: RTL

//  Parametrised successor of the 2-flop reset synchronizer. Synchronizes deassertion of async RST into CLK,

---
 rtl/rst_seq_pkg.sv | 30 +++
 rtl/rst_sync_core.sv | 20 ++
 rtl/rst_seq_sync.sv | 114 +++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the sequenced reset synchronizer.
// FSM state encoding, clog2 and the phase-counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // The counter must hold values up to max(STRETCH_CYC, GAP_CYC).
  function automatic int cnt_width(input int stretch, input int gap);
    int m;
    int w;
    m = (stretch > gap) ? stretch : gap;
    w = clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_sync_core.sv
// NUM_STAGES-deep reset-deassertion synchronizer; all flops clear asynchronously on i_rst.
// o_rst_ok rises on the NUM_STAGES-th clock edge after i_rst falls.
module rst_sync_core #(
  parameter int NUM_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst_ok
);

  logic [NUM_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[NUM_STAGES-2:0], 1'b1};
  end

  assign o_rst_ok = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchronizer with stretch and ordered, gapped release of NUM_CH active-low channel resets.
// Optional soft-reset request port enabled by defining RST_SEQ_SW_REQ_EN.
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 4,
  parameter int STRETCH_CYC = 8,
  parameter int GAP_CYC     = 4
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef RST_SEQ_SW_REQ_EN
  input  logic              SW_RST_REQ,
`endif
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE
);

  localparam int CW = cnt_width(STRETCH_CYC, GAP_CYC);
  localparam int IW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] ST_LAST  = CW'(STRETCH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CH - 1);

  logic              w_rst_ok;
  logic              w_sw_req;
  logic              w_first_rel;
  rst_state_e        r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [NUM_CH-1:0] r_sync;
  logic              r_done;
  logic              r_hold;

  rst_sync_core #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .i_clk    (CLK),
    .i_rst    (RST),
    .o_rst_ok (w_rst_ok)
  );

`ifdef RST_SEQ_SW_REQ_EN
  assign w_sw_req = SW_RST_REQ;
`else
  assign w_sw_req = 1'b0;
`endif

  // Channel 0 releases on the edge that completes the stretch; the ASSERT exit
  // edge already counts as the first stretch edge.
  assign w_first_rel = ((r_state == ST_ASSERT) && w_rst_ok && (STRETCH_CYC == 1)) ||
                       ((r_state == ST_STRETCH) && (r_cnt == ST_LAST));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sync  <= '0;
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
    end else if ((r_state != ST_ASSERT) && w_sw_req) begin
      r_state <= ST_STRETCH;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sync  <= '0;
      r_done  <= 1'b0;
      r_hold  <= 1'b1;
    end else if (r_hold) begin
      // First edge after the soft request drops does not count toward the stretch.
      r_hold <= 1'b0;
    end else if (w_first_rel) begin
      r_sync <= NUM_CH'(1);
      r_cnt  <= '0;
      if (NUM_CH == 1) begin
        r_state <= ST_RUN;
        r_done  <= 1'b1;
      end else begin
        r_state <= ST_RELEASE;
        r_idx   <= IW'(1);
      end
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (w_rst_ok) begin
            r_state <= ST_STRETCH;
            r_cnt   <= CW'(1);
          end
        end
        ST_STRETCH: r_cnt <= r_cnt + 1'b1;
        ST_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            r_sync <= (r_sync << 1) | NUM_CH'(1);
            r_cnt  <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_RUN;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign SYNC_RST = r_sync;
  assign RST_DONE = r_done;

endmodule
